// File: rtl/rf_access_seq.sv
// Operand-fetch / write-back sequencer for a 1R1W register file.
// Serialises the Rb/Rc reads, hands operands to the ALU and writes the result back to Ra.
module rf_access_seq #(
    parameter int depth = 4,
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             rb_en,
    input  logic             rc_en,
    input  logic             ba_mode,
    input  logic             wb_en,
    input  logic [depth-1:0] ra,
    input  logic [depth-1:0] rb,
    input  logic [depth-1:0] rc,
    output logic [depth-1:0] rf_r_addr,
    input  logic [width-1:0] rf_r_data,
    output logic             rf_wr_en,
    output logic [depth-1:0] rf_w_addr,
    output logic [width-1:0] rf_w_data,
    output logic [width-1:0] opa,
    output logic [width-1:0] opb,
    output logic             opnd_valid,
    input  logic             opnd_ready,
    input  logic [width-1:0] res_data,
    input  logic             res_valid,
    output logic             res_ready,
    output logic             busy,
    output logic             done,
    output logic [2:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // the sender holds valid and its data stable until that edge.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_B     = 3'd1,
        S_RD_C     = 3'd2,
        S_ISSUE    = 3'd3,
        S_WAIT_RES = 3'd4,
        S_WB       = 3'd5
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [depth-1:0] r_ra;
    logic [depth-1:0] r_rb;
    logic [depth-1:0] r_rc;
    logic             r_rc_en;
    logic             r_ba_mode;
    logic             r_wb_en;
    logic [width-1:0] r_opa;
    logic [width-1:0] r_opb;
    logic [width-1:0] r_result;
    logic             w_rb_zero;

    assign w_rb_zero = r_ba_mode && (r_rb == '0);

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (rb_en) begin
                        w_next = S_RD_B;
                    end else if (rc_en) begin
                        w_next = S_RD_C;
                    end else begin
                        w_next = S_ISSUE;
                    end
                end
            end
            S_RD_B:     w_next = r_rc_en ? S_RD_C : S_ISSUE;
            S_RD_C:     w_next = S_ISSUE;
            S_ISSUE:    if (opnd_ready) w_next = S_WAIT_RES;
            S_WAIT_RES: if (res_valid) w_next = S_WB;
            S_WB:       w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Operands clear on the start edge so a skipped source reads as zero.
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_ra      <= '0;
            r_rb      <= '0;
            r_rc      <= '0;
            r_rc_en   <= 1'b0;
            r_ba_mode <= 1'b0;
            r_wb_en   <= 1'b0;
            r_opa     <= '0;
            r_opb     <= '0;
            r_result  <= '0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_ra      <= ra;
                r_rb      <= rb;
                r_rc      <= rc;
                r_rc_en   <= rc_en;
                r_ba_mode <= ba_mode;
                r_wb_en   <= wb_en;
                r_opa     <= '0;
                r_opb     <= '0;
            end
            if (r_state == S_RD_B) begin
                r_opa <= w_rb_zero ? '0 : rf_r_data;
            end
            if (r_state == S_RD_C) begin
                r_opb <= rf_r_data;
            end
            if (r_state == S_WAIT_RES && res_valid) begin
                r_result <= res_data;
            end
        end
    end

    always_comb begin
        rf_r_addr  = '0;
        rf_wr_en   = 1'b0;
        rf_w_addr  = '0;
        rf_w_data  = '0;
        opnd_valid = 1'b0;
        res_ready  = 1'b0;
        done       = 1'b0;
        busy       = (r_state != S_IDLE);
        case (r_state)
            S_RD_B:     rf_r_addr = r_rb;
            S_RD_C:     rf_r_addr = r_rc;
            S_ISSUE:    opnd_valid = 1'b1;
            S_WAIT_RES: res_ready = 1'b1;
            S_WB: begin
                rf_wr_en  = r_wb_en;
                rf_w_addr = r_ra;
                rf_w_data = r_result;
                done      = 1'b1;
            end
            default: ;
        endcase
    end

    assign opa       = r_opa;
    assign opb       = r_opb;
    assign dbg_state = r_state;

endmodule

// File: doc/rf_access_seq.md
# rf_access_seq

Operand-fetch and write-back sequencer that sits between instruction decode and the single-read-port, single-write-port register file. It serialises up to two source reads (Rb, Rc) through the one read port into latched operands A and B. It hands the operands to the ALU over a valid/ready handshake, accepts the ALU result over a second handshake, and issues one synchronous write to Ra.

## Interface
- depth, 4, register address width (2^depth registers)
- width, 32, data width
- clk  in  1  rising-edge clock
- clr  in  1  synchronous, active-low reset
- start  in  1  begin an operation; sampled only in IDLE
- rb_en, rc_en  in  1  source Rb / Rc is required
- ba_mode  in  1  Rb==0 reads as zero (base-address rule)
- wb_en  in  1  result is written to Ra
- ra, rb, rc  in  depth  destination / source addresses
- rf_r_addr  out  depth  register file read address
- rf_r_data  in  width  register file read data (combinational from rf_r_addr)
- rf_wr_en  out  1  register file write enable
- rf_w_addr  out  depth  register file write address
- rf_w_data  out  width  register file write data
- opa, opb  out  width  latched operands
- opnd_valid  out  1  operands offered to ALU
- opnd_ready  in  1  ALU accepts operands
- res_data  in  width  ALU result
- res_valid  in  1  result offered
- res_ready  out  1  sequencer accepts result
- busy  out  1  not in IDLE
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, RD_B, RD_C, ISSUE, WAIT_RES, WB.
- IDLE: when start=1, latch ra/rb/rc/rb_en/rc_en/ba_mode/wb_en. Next state is RD_B if rb_en, else RD_C if rc_en, else ISSUE. Skipped operands load 0 on the start edge.
- RD_B: rf_r_addr=rb_l. At the clock edge, opa <= (ba_mode_l && rb_l==0) ? 0 : rf_r_data. Next state is RD_C if rc_en_l, else ISSUE.
- RD_C: rf_r_addr=rc_l. At the clock edge, opb <= rf_r_data. Next state is ISSUE.
- rf_r_addr=0 in all other states.
- ISSUE: opnd_valid=1. On opnd_valid&&opnd_ready, go to WAIT_RES. opa/opb hold stable while valid is high and until the next start.
- WAIT_RES: res_ready=1. On res_valid&&res_ready, capture res_data into the result register and go to WB.
- WB: rf_wr_en=wb_en_l, rf_w_addr=ra_l, rf_w_data=result register, done=1. Next state is IDLE.
- Write to any register, including R0, is permitted; ba_mode affects reads only.
- start outside IDLE is ignored; changes on ra/rb/rc/enables after the start edge have no effect.
- Ra equal to Rb/Rc is legal: reads complete before the write.

## Timing
- Reset (clr=0 at a clock edge): state IDLE; opa=opb=0; result register 0; all outputs 0.
- Reset mid-operation aborts with no write and no done. clr has priority over every other input.
- rf_wr_en is asserted for exactly one cycle per operation, never outside WB.
- Latency, with start accepted at edge 0 and both sources enabled:
  - RD_B in cycle 1, RD_C in cycle 2;
  - opnd_valid high from cycle 3;
  - with ready/valid already high, WAIT_RES is cycle 4 and WB is cycle 5;
  - the register file updates at the end of cycle 5; IDLE in cycle 6.
- Each disabled source removes one cycle.
- The next start is accepted in the cycle after done, i.e. back-to-back operations have no dead cycle beyond IDLE.
- A read of a register written by the preceding operation returns the new value, since the write completes before the next RD state.

## Test plan
- Reset: R2=0x11, R3=0x22 preloaded; drive clr=0 for 2 cycles -> all outputs 0, busy=0. Then, with clr=1 and start, rb=2, rc=3 -> opa=0x11, opb=0x22 at the cycle-3 opnd_valid.
- Full op: rb=2, rc=3, ra=5, wb_en=1; ALU returns 0x33 with ready/valid tied high -> rf_wr_en one cycle in cycle 5 with w_addr=5, w_data=0x33, done the same cycle.
- Base rule: R0=0xDEAD, rb=0, ba_mode=1 -> opa=0. Same with ba_mode=0 -> opa=0xDEAD.
- Backpressure: hold opnd_ready=0 for 4 cycles and res_valid=0 for 3 cycles -> opnd_valid stays high with opa/opb stable, res_ready stays high, no write until both handshakes fire.
- Skips and no-write: rb_en=1, rc_en=0, wb_en=0 -> opb=0, opnd_valid in cycle 2, done pulse with rf_wr_en=0.
- Abort and chaining: clr=0 during WAIT_RES -> no write, IDLE next cycle. Then two back-to-back ops where op2 reads op1's Ra -> op2 operand equals op1's result.
